// File: rtl/mc_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its datapath:
// FSM states, opcode/funct values, mux/operation selects, instruction classes.
package mc_defs;

  typedef enum logic [2:0] {
    ST_FETCH = 3'b000,
    ST_DCD   = 3'b001,
    ST_EXE   = 3'b010,
    ST_MEM   = 3'b011,
    ST_WB    = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_SHL2 = 2'b11;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  // Exactly one field is set for any op/funct pair; unknown pairs land on nop.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic nop;
  } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to one-hot class vector.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  // Anything not explicitly recognised is treated as a nop.
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_ADDU)      cls.addu = 1'b1;
        else if (funct == FUNCT_SUBU) cls.subu = 1'b1;
        else                          cls.nop  = 1'b1;
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      default: cls.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: state register, next-state logic and Moore/Mealy
// control outputs for the FETCH/DCD/EXE/MEM/WB sequence.
module mc_ctrl
  import mc_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic [1:0] npc_op,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_to_reg,
  output logic [2:0] state,
  output logic       instr_done
);

  instr_class_t cls;
  state_t       state_q;
  state_t       state_d;
  logic         hold_alu_src;
  logic [1:0]   hold_ext_op;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  assign state = state_q;

  // State register; reset drops straight back to FETCH without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Datapath operand selects set in EXE and kept through MEM/WB.
  always_comb begin
    hold_alu_src = cls.ori | cls.lui | cls.lw | cls.sw;
    hold_ext_op  = EXT_SIGN;
    if (cls.ori)      hold_ext_op = EXT_ZERO;
    else if (cls.lui) hold_ext_op = EXT_LUI;
    else if (cls.beq) hold_ext_op = EXT_SHL2;
  end

  // Next-state and control outputs; strobes are masked while reset is held.
  always_comb begin
    state_d    = state_q;
    pc_wr      = 1'b0;
    npc_op     = NPC_PC4;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = EXT_SIGN;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        npc_op  = NPC_PC4;
        state_d = ST_DCD;
      end
      ST_DCD: begin
        if (cls.j) begin
          pc_wr      = 1'b1;
          npc_op     = NPC_JUMP;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (cls.nop) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        alu_src = hold_alu_src;
        ext_op  = hold_ext_op;
        if (cls.subu || cls.beq) alu_op = ALU_SUB;
        else if (cls.ori)        alu_op = ALU_OR;
        if (cls.beq) begin
          pc_wr      = zero;
          npc_op     = NPC_BRANCH;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (cls.lw || cls.sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        alu_src = hold_alu_src;
        ext_op  = hold_ext_op;
        mem_rd  = cls.lw;
        mem_wr  = cls.sw;
        if (mem_ready) begin
          if (cls.lw) begin
            state_d = ST_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        alu_src    = hold_alu_src;
        ext_op     = hold_ext_op;
        reg_wr     = 1'b1;
        reg_dst    = cls.addu | cls.subu;
        mem_to_reg = cls.lw;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (reset) begin
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
